// File: rtl/imem_loader_if.sv
// Byte-stream receive channel and instruction-memory write port of the boot loader.
interface imem_loader_if #(
  parameter int ADDR_W = 16
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time loader: parses an address/count/data/checksum byte frame and writes
// 16-bit words into instruction memory while holding the CPU in stall.
module imem_loader #(
  parameter int ADDR_W = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  imem_loader_if.slave  bus,
  output logic          cpu_stall,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {IDLE, HDR, DATA_HI, DATA_LO, CHK, DONE} state_t;

  state_t            state;
  logic [1:0]        hdr_idx;
  logic [7:0]        hi_byte;
  logic [7:0]        chk;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       words_left;
  logic              accept;

  assign accept    = bus.rx_valid && bus.rx_ready;
  assign cpu_stall = busy;

  // hi_byte is shared: it holds ADDR_HI, CNT_HI or a data HI byte depending on state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      hdr_idx      <= 2'd0;
      hi_byte      <= 8'h00;
      chk          <= 8'h00;
      addr         <= '0;
      words_left   <= 16'd0;
      bus.rx_ready <= 1'b0;
      bus.wr_en    <= 1'b0;
      bus.wr_addr  <= '0;
      bus.wr_data  <= 16'h0000;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      bus.wr_en <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state        <= HDR;
            busy         <= 1'b1;
            bus.rx_ready <= 1'b1;
            err          <= 1'b0;
            hdr_idx      <= 2'd0;
            chk          <= 8'h00;
          end
        end
        HDR: begin
          if (accept) begin
            chk     <= chk ^ bus.rx_data;
            hi_byte <= bus.rx_data;
            hdr_idx <= hdr_idx + 2'd1;
            case (hdr_idx)
              2'd1: addr <= ADDR_W'({hi_byte, bus.rx_data});
              2'd3: begin
                words_left <= {hi_byte, bus.rx_data};
                state      <= ({hi_byte, bus.rx_data} == 16'd0) ? CHK : DATA_HI;
              end
              default: ;
            endcase
          end
        end
        DATA_HI: begin
          if (accept) begin
            chk     <= chk ^ bus.rx_data;
            hi_byte <= bus.rx_data;
            state   <= DATA_LO;
          end
        end
        DATA_LO: begin
          // Write is issued one cycle after the LO byte; address wraps naturally at 2^ADDR_W
          if (accept) begin
            chk         <= chk ^ bus.rx_data;
            bus.wr_en   <= 1'b1;
            bus.wr_addr <= addr;
            bus.wr_data <= {hi_byte, bus.rx_data};
            addr        <= addr + ADDR_W'(1);
            words_left  <= words_left - 16'd1;
            state       <= (words_left == 16'd1) ? CHK : DATA_HI;
          end
        end
        CHK: begin
          if (accept) begin
            err          <= (bus.rx_data != chk);
            done         <= 1'b1;
            bus.rx_ready <= 1'b0;
            state        <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
